// File: rtl/mem_port_arbiter_if.sv
// Bundle between the arbiter, the IF/MEM pipeline stages and the memory.
// master = arbiter side, slave = stages + memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_done;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              stall_if;
  logic              stall_mem;
  logic              busy;

  modport master (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  mem_rdata, mem_ack,
    output if_rdata, if_valid,
    output dm_rdata, dm_done,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output stall_if, stall_mem, busy
  );

  modport slave (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output mem_rdata, mem_ack,
    input  if_rdata, if_valid,
    input  dm_rdata, dm_done,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  stall_if, stall_mem, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// IF/MEM arbiter for one single-ported memory, data first with streak cap.
// Optional ARB_STATS_EN macro adds the conflict_cnt statistics output.
module mem_port_arbiter #(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic clk,
  input  logic reset,
`ifdef ARB_STATS_EN
  output logic [15:0] conflict_cnt,
`endif
  mem_port_arbiter_if.master bus
);

  localparam int SW = (MAX_DATA_STREAK < 1) ? 1
                    : $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  typedef enum logic [1:0] {IDLE, DATA, FETCH} state_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic [SW-1:0]     r_streak;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic              r_if_valid;
  logic [DATA_W-1:0] r_dm_rdata;
  logic              r_dm_done;
  logic              w_dm_act;
  logic              w_if_act;
  logic              w_cap;
  logic              w_grant_d;
  logic              w_grant_f;

  // Mask finishing requesters, pick a winner, compute next state
  always_comb begin
    w_dm_act   = bus.dm_req & ~r_dm_done;
    w_if_act   = bus.if_req & ~r_if_valid;
    w_cap      = (MAX_DATA_STREAK != 0) && (r_streak == STREAK_MAX);
    w_grant_d  = 1'b0;
    w_grant_f  = 1'b0;
    w_state_nx = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_dm_act && !(w_if_act && w_cap)) begin
          w_grant_d  = 1'b1;
          w_state_nx = DATA;
        end else if (w_if_act) begin
          w_grant_f  = 1'b1;
          w_state_nx = FETCH;
        end
      end
      DATA, FETCH: begin
        if (bus.mem_ack) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nx;
  end

  // Data-grant streak while fetch is waiting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_streak <= '0;
    end else if (w_grant_f) begin
      r_streak <= '0;
    end else if (w_grant_d) begin
      if (!bus.if_req)                r_streak <= '0;
      else if (r_streak != STREAK_MAX) r_streak <= r_streak + 1'b1;
    end
  end

  // Memory command issue and completion capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_if_valid  <= 1'b0;
      r_dm_rdata  <= '0;
      r_dm_done   <= 1'b0;
    end else begin
      r_if_valid <= 1'b0;
      r_dm_done  <= 1'b0;
      if (w_grant_d) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= bus.dm_we;
        r_mem_addr  <= bus.dm_addr;
        r_mem_wdata <= bus.dm_wdata;
      end else if (w_grant_f) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= 1'b0;
        r_mem_addr  <= bus.if_addr;
        r_mem_wdata <= '0;
      end else if (r_state != IDLE && bus.mem_ack) begin
        r_mem_req <= 1'b0;
        if (r_state == DATA) begin
          r_dm_done <= 1'b1;
          if (!r_mem_we) r_dm_rdata <= bus.mem_rdata;
        end else begin
          r_if_valid <= 1'b1;
          r_if_rdata <= bus.mem_rdata;
        end
      end
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] r_conflict;

  // Count idle cycles where both live requests compete
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_conflict <= '0;
    end else if (r_state == IDLE && w_dm_act && w_if_act
                 && r_conflict != 16'hFFFF) begin
      r_conflict <= r_conflict + 16'd1;
    end
  end

  assign conflict_cnt = r_conflict;
`endif

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.if_valid  = r_if_valid;
  assign bus.dm_rdata  = r_dm_rdata;
  assign bus.dm_done   = r_dm_done;
  assign bus.stall_if  = bus.if_req & ~r_if_valid;
  assign bus.stall_mem = bus.dm_req & ~r_dm_done;
  assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a variable-latency memory model.
// Build with +define+ARB_STATS_EN to also exercise conflict_cnt.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_run = 0;
  int   n_fail = 0;
  logic r_if_req = 1'b0;
  logic r_if_gate = 1'b0;
  logic ack_force = 1'b0;
  int   wait_n = 0;
  int   ack_cnt = 0;
  logic [9:0] seq;
  logic [9:0] exp_seq;
  int   ng;
  logic prev;

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus();

`ifdef ARB_STATS_EN
  logic [15:0] conflict_cnt;
`endif

  mem_port_arbiter #(
    .ADDR_W(16),
    .DATA_W(16),
    .MAX_DATA_STREAK(4)
  ) dut (
    .clk(clk),
    .reset(reset),
`ifdef ARB_STATS_EN
    .conflict_cnt(conflict_cnt),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.if_req  = r_if_req & ~(r_if_gate & bus.dm_done);
  assign bus.mem_ack = (bus.mem_req && ack_cnt == wait_n) || ack_force;

  always @(posedge clk) begin
    if (!bus.mem_req || bus.mem_ack) ack_cnt <= 0;
    else                             ack_cnt <= ack_cnt + 1;
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.if_addr   = '0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
    bus.mem_rdata = '0;

    tick;
    tick;
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_if_valid", bus.if_valid, 0);
    check("rst_dm_done", bus.dm_done, 0);
    check("rst_if_rdata", bus.if_rdata, 0);
    check("rst_dm_rdata", bus.dm_rdata, 0);
    reset = 1'b0;

    // fetch only, zero wait
    r_if_req      = 1'b1;
    bus.if_addr   = 16'h0010;
    bus.mem_rdata = 16'hABCD;
    wait_n        = 0;
    #1;
    check("t1_stall_pre", bus.stall_if, 1);
    tick;
    check("t1_mem_req", bus.mem_req, 1);
    check("t1_mem_addr", bus.mem_addr, 16'h0010);
    check("t1_mem_we", bus.mem_we, 0);
    check("t1_busy", bus.busy, 1);
    tick;
    check("t1_if_valid", bus.if_valid, 1);
    check("t1_if_rdata", bus.if_rdata, 16'hABCD);
    check("t1_stall_if", bus.stall_if, 0);
    check("t1_mem_req_off", bus.mem_req, 0);
    r_if_req = 1'b0;
    tick;
    check("t1_valid_pulse", bus.if_valid, 0);
    check("t1_rdata_hold", bus.if_rdata, 16'hABCD);

    // data write, 3 wait states
    bus.dm_req    = 1'b1;
    bus.dm_we     = 1'b1;
    bus.dm_addr   = 16'h0040;
    bus.dm_wdata  = 16'h1234;
    bus.mem_rdata = 16'hBEEF;
    wait_n        = 3;
    tick;
    check("t2_mem_addr", bus.mem_addr, 16'h0040);
    check("t2_mem_wdata", bus.mem_wdata, 16'h1234);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_req%0d", i), bus.mem_req, 1);
      check($sformatf("t2_we%0d", i), bus.mem_we, 1);
      check($sformatf("t2_stall%0d", i), bus.stall_mem, 1);
      check($sformatf("t2_done%0d", i), bus.dm_done, 0);
      tick;
    end
    check("t2_dm_done", bus.dm_done, 1);
    check("t2_stall_off", bus.stall_mem, 0);
    check("t2_req_off", bus.mem_req, 0);
    check("t2_rdata_hold", bus.dm_rdata, 0);
    bus.dm_req = 1'b0;
    tick;
    check("t2_done_pulse", bus.dm_done, 0);

    // both request, dm_req held through its done cycle
    wait_n        = 0;
    bus.dm_req    = 1'b1;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = 16'h0080;
    bus.mem_rdata = 16'h5555;
    r_if_req      = 1'b1;
    bus.if_addr   = 16'h0020;
    tick;
    check("t5_first_addr", bus.mem_addr, 16'h0080);
    check("t5_first_we", bus.mem_we, 0);
    tick;
    check("t5_dm_done", bus.dm_done, 1);
    check("t5_dm_rdata", bus.dm_rdata, 16'h5555);
    check("t5_no_reissue", bus.mem_req, 0);
    check("t5_stall_if", bus.stall_if, 1);
    check("t5_stall_mem", bus.stall_mem, 0);
    bus.mem_rdata = 16'h7777;
    tick;
    check("t5_fetch_req", bus.mem_req, 1);
    check("t5_fetch_addr", bus.mem_addr, 16'h0020);
    bus.dm_req = 1'b0;
    tick;
    check("t5_if_valid", bus.if_valid, 1);
    check("t5_if_rdata", bus.if_rdata, 16'h7777);
    check("t5_dm_hold", bus.dm_rdata, 16'h5555);
    r_if_req = 1'b0;
    tick;

    // streak cap: fetch waits at every data grant
    r_if_gate   = 1'b1;
    r_if_req    = 1'b1;
    bus.if_addr = 16'h0200;
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 16'h0100;
    exp_seq     = 10'b0111101111;
    seq         = '0;
    ng          = 0;
    prev        = bus.mem_req;
    for (int c = 0; c < 80 && ng < 10; c++) begin
      tick;
      if (bus.mem_req && !prev) begin
        seq[ng] = (bus.mem_addr == 16'h0100);
        ng++;
      end
      prev = bus.mem_req;
    end
    check("t3_grant_cnt", ng, 10);
    for (int i = 0; i < 10; i++)
      check($sformatf("t3_grant%0d", i), seq[i], exp_seq[i]);
    bus.dm_req = 1'b0;
    r_if_req   = 1'b0;
    r_if_gate  = 1'b0;
    tick;
    tick;
    tick;

    // reset in the middle of a data transaction
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b1;
    bus.dm_addr = 16'h0300;
    wait_n      = 5;
    tick;
    check("t4_req_on", bus.mem_req, 1);
    #2;
    reset = 1'b1;
    #1;
    check("t4_req_drop", bus.mem_req, 0);
    check("t4_busy", bus.busy, 0);
    bus.dm_req = 1'b0;
    ack_force  = 1'b1;
    tick;
    reset = 1'b0;
    tick;
    check("t4_no_done", bus.dm_done, 0);
    check("t4_idle", bus.busy, 0);
    check("t4_req_off", bus.mem_req, 0);
    ack_force = 1'b0;
    tick;
    check("t4_no_done2", bus.dm_done, 0);

`ifdef ARB_STATS_EN
    wait_n = 0;
    reset  = 1'b1;
    tick;
    reset       = 1'b0;
    r_if_gate   = 1'b1;
    r_if_req    = 1'b1;
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    for (int i = 0; i < 7; i++) tick;
    check("t6_conflict", conflict_cnt, 3);
    bus.dm_req = 1'b0;
    r_if_req   = 1'b0;
    r_if_gate  = 1'b0;
    tick;
    tick;
    reset = 1'b1;
    #1;
    check("t6_conflict_rst", conflict_cnt, 0);
    tick;
    reset = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
